// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file constants: MIPS register numbers and
//               default geometry, used by decoder, syscall unit and regfile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 5;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_V0   = 2;
    localparam int unsigned REG_A0   = 4;
    localparam int unsigned REG_RA   = 31;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_2r1w_if.sv
// ============================================================================
// Module      : regfile_2r1w_if
// Description : Read/write/debug port bundle of the 2R1W register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_2r1w_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);

    logic [DEPTH_LOG2-1:0] RA;
    logic [DEPTH_LOG2-1:0] RB;
    logic [DEPTH_LOG2-1:0] RW;
    logic                  WE;
    logic [WIDTH-1:0]      Din;
    logic [WIDTH-1:0]      R1;
    logic [WIDTH-1:0]      R2;
    logic [DEPTH_LOG2-1:0] DbgA;
    logic [WIDTH-1:0]      DbgD;

    modport master (
        output RA, RB, RW, WE, Din, DbgA,
        input  R1, R2, DbgD
    );

    modport slave (
        input  RA, RB, RW, WE, Din, DbgA,
        output R1, R2, DbgD
    );

endinterface : regfile_2r1w_if

`default_nettype wire

// File: rtl/regfile_2r1w_register.sv
// ============================================================================
// Module      : register
// Description : Enabled WIDTH-bit storage cell with asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register #(
    parameter int unsigned WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] Data_in,
    input  wire logic             Enable,
    input  wire logic             clk,
    input  wire logic             clr,
    output logic      [WIDTH-1:0] Data_out
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_data <= '0;
        end else if (Enable) begin
            r_data <= Data_in;
        end
    end

    assign Data_out = r_data;

endmodule : register

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module      : regfile_2r1w
// Description : 32x32 MIPS register file, two async read ports, one sync
//               write port, one debug read port; entry 0 reads as zero.
//               Optional macro REGFILE_BYPASS_EN adds write-through on R1/R2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  wire logic      clk,
    input  wire logic      clr,
    regfile_2r1w_if.slave  bus
);

    localparam int unsigned c_DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] w_regs [c_DEPTH];

    // $zero has no storage cell
    assign w_regs[REG_ZERO] = '0;

    for (genvar i = 1; i < c_DEPTH; i++) begin : g_entry
        logic w_enable;

        assign w_enable = bus.WE & (bus.RW == DEPTH_LOG2'(i));

        register #(
            .WIDTH (WIDTH)
        ) u_register (
            .Data_in  (bus.Din),
            .Enable   (w_enable),
            .clk      (clk),
            .clr      (clr),
            .Data_out (w_regs[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    logic w_wr_active;

    // RW=0 is excluded so address 0 can never be forwarded non-zero data
    assign w_wr_active = bus.WE & ~clr & (bus.RW != '0);
    assign bus.R1 = (w_wr_active && (bus.RA == bus.RW)) ? bus.Din : w_regs[bus.RA];
    assign bus.R2 = (w_wr_active && (bus.RB == bus.RW)) ? bus.Din : w_regs[bus.RB];
`else
    assign bus.R1 = w_regs[bus.RA];
    assign bus.R2 = w_regs[bus.RB];
`endif

    assign bus.DbgD = w_regs[bus.DbgA];

endmodule : regfile_2r1w

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// ============================================================================
// Module      : tb_regfile_2r1w
// Description : Directed self-checking bench for regfile_2r1w.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic clk;
    logic clr;
    int   errors;
    int   checks;

    regfile_2r1w_if #(.WIDTH(32), .DEPTH_LOG2(5)) bus ();

    regfile_2r1w #(
        .WIDTH      (32),
        .DEPTH_LOG2 (5)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        bus.WE  = 1'b1;
        bus.RW  = addr;
        bus.Din = data;
        @(posedge clk);
        #1;
        bus.WE  = 1'b0;
    endtask

    initial begin
        logic [31:0] exp1;
        logic [31:0] exp2;
        errors   = 0;
        checks   = 0;
        clr      = 1'b1;
        bus.RA   = '0;
        bus.RB   = '0;
        bus.RW   = '0;
        bus.WE   = 1'b0;
        bus.Din  = '0;
        bus.DbgA = '0;

        // reset state
        #3;
        check("reset_r1", bus.R1, 32'h0);
        check("reset_r2", bus.R2, 32'h0);
        check("reset_dbg", bus.DbgD, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        // basic write/read of r8
        bus.WE = 1'b1; bus.RW = 5'd8; bus.Din = 32'hDEADBEEF;
        bus.RA = 5'd8; bus.RB = 5'd8; bus.DbgA = 5'd8;
        #1;
        check("wr8_pre_r1", bus.R1, c_BYPASS ? 32'hDEADBEEF : 32'h0);
        check("wr8_pre_dbg", bus.DbgD, 32'h0);
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
        #1;
        check("wr8_r1", bus.R1, 32'hDEADBEEF);
        check("wr8_r2", bus.R2, 32'hDEADBEEF);
        check("wr8_dbg", bus.DbgD, 32'hDEADBEEF);

        // writes to $zero are discarded
        bus.RA = 5'd0; bus.DbgA = 5'd0;
        bus.WE = 1'b1; bus.RW = 5'd0; bus.Din = 32'hFFFFFFFF;
        #1;
        check("zero_pre_r1", bus.R1, 32'h0);
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
        #1;
        check("zero_r1", bus.R1, 32'h0);
        check("zero_dbg", bus.DbgD, 32'h0);

        // same-cycle read/write of r3
        write_reg(5'd3, 32'h1);
        bus.RA = 5'd3; bus.DbgA = 5'd3;
        bus.WE = 1'b1; bus.RW = 5'd3; bus.Din = 32'hA5A5A5A5;
        #1;
        check("byp_pre_r1", bus.R1, c_BYPASS ? 32'hA5A5A5A5 : 32'h1);
        check("byp_pre_dbg", bus.DbgD, 32'h1);
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
        #1;
        check("byp_post_r1", bus.R1, 32'hA5A5A5A5);
        check("byp_post_dbg", bus.DbgD, 32'hA5A5A5A5);

        // mid-cycle asynchronous clear
        write_reg(5'd5, 32'h12345678);
        bus.RA = 5'd5; bus.RB = 5'd8; bus.DbgA = 5'd5;
        #1;
        check("clr_pre_r1", bus.R1, 32'h12345678);
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("clr_r1", bus.R1, 32'h0);
        check("clr_r2", bus.R2, 32'h0);
        check("clr_dbg", bus.DbgD, 32'h0);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("clr_after_edge_r1", bus.R1, 32'h0);

        // clr held across a write edge, then released
        @(negedge clk);
        clr = 1'b1;
        bus.WE = 1'b1; bus.RW = 5'd2; bus.Din = 32'd7; bus.DbgA = 5'd2;
        @(posedge clk);
        #1;
        check("ovl_blocked_dbg", bus.DbgD, 32'h0);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
        #1;
        check("ovl_written_dbg", bus.DbgD, 32'd7);

        // dual-port sweep over every address
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            bus.RA = 5'(i);
            bus.RB = 5'(31 - i);
            exp1 = 32'(i) * 32'h01010101;
            exp2 = 32'(31 - i) * 32'h01010101;
            #1;
            check($sformatf("sweep_r1[%0d]", i), bus.R1, exp1);
            check($sformatf("sweep_r2[%0d]", 31 - i), bus.R2, exp2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_2r1w

`default_nettype wire
